// File: rtl/demux32_1x16_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux32_1x16_seq_pkg
//  Description : Shared widths and FSM state encoding for the registered
//                1-to-16 word demultiplexer and its select decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux32_1x16_seq_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int SEL_WIDTH  = 4;
    localparam int NUM_OUT    = 16;

    // INIT is the one-cycle not-ready state after reset or clear
    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_IDLE = 2'b01,
        ST_SEQ  = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/demux32_1x16_seq_decoder_4x16.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_4x16
//  Description : Combinational select-to-one-hot decoder with enable. Feeds
//                the per-register write enables and the next strobe value.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_4x16
    import demux32_1x16_seq_pkg::*;
(
    input  logic [SEL_WIDTH-1:0] i_sel,
    input  logic                 i_en,
    output logic [NUM_OUT-1:0]   o_onehot
);

    // One bit set at the selected position, all zero when disabled
    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/demux32_1x16_seq.sv
`default_nettype none
// ============================================================================
//  Module      : demux32_1x16_seq
//  Description : Registered 1-to-16 demultiplexer for data words. Addressed
//                mode writes Y[S]; auto mode walks a pointer from S up to 15,
//                one word per accepted transfer, pulsing DONE on the Y15 write.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux32_1x16_seq #(
    parameter int DATA_WIDTH = demux32_1x16_seq_pkg::DATA_WIDTH,
    parameter int SEL_WIDTH  = demux32_1x16_seq_pkg::SEL_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     D,
    input  logic [SEL_WIDTH-1:0]      S,
    input  logic                      AUTO,
    input  logic                      VALID,
    output logic                      READY,
    input  logic                      CLR,
    output logic [DATA_WIDTH-1:0]     Y0,
    output logic [DATA_WIDTH-1:0]     Y1,
    output logic [DATA_WIDTH-1:0]     Y2,
    output logic [DATA_WIDTH-1:0]     Y3,
    output logic [DATA_WIDTH-1:0]     Y4,
    output logic [DATA_WIDTH-1:0]     Y5,
    output logic [DATA_WIDTH-1:0]     Y6,
    output logic [DATA_WIDTH-1:0]     Y7,
    output logic [DATA_WIDTH-1:0]     Y8,
    output logic [DATA_WIDTH-1:0]     Y9,
    output logic [DATA_WIDTH-1:0]     Y10,
    output logic [DATA_WIDTH-1:0]     Y11,
    output logic [DATA_WIDTH-1:0]     Y12,
    output logic [DATA_WIDTH-1:0]     Y13,
    output logic [DATA_WIDTH-1:0]     Y14,
    output logic [DATA_WIDTH-1:0]     Y15,
    output logic [(2**SEL_WIDTH)-1:0] STB,
    output logic [SEL_WIDTH-1:0]      PTR,
    output logic                      DONE
);

    import demux32_1x16_seq_pkg::*;

    localparam int                   c_NUM_OUT = 2**SEL_WIDTH;
    localparam logic [SEL_WIDTH-1:0] c_LAST    = '1;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_ready;
    logic [SEL_WIDTH-1:0]   r_ptr;
    logic [SEL_WIDTH-1:0]   w_ptr_nxt;
    logic [SEL_WIDTH-1:0]   w_wr_sel;
    logic                   w_wr_en;
    logic                   w_xfer;
    logic                   w_done_nxt;
    logic                   r_done;
    logic [c_NUM_OUT-1:0]   w_wr_onehot;
    logic [c_NUM_OUT-1:0]   r_stb;
    logic [DATA_WIDTH-1:0]  r_y [c_NUM_OUT];

    // READY is registered, so it is already low throughout INIT
    assign w_xfer = VALID & r_ready;

    decoder_4x16 u_decoder (
        .i_sel    (w_wr_sel),
        .i_en     (w_wr_en),
        .o_onehot (w_wr_onehot)
    );

    // Next-state, pointer, write select and DONE decisions
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_wr_sel    = S;
        w_wr_en     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_xfer) begin
                    w_wr_en = 1'b1;
                    if (AUTO) begin
                        if (S == c_LAST) begin
                            w_done_nxt = 1'b1;
                            w_ptr_nxt  = '0;
                        end else begin
                            w_ptr_nxt   = S + 1'b1;
                            w_state_nxt = ST_SEQ;
                        end
                    end
                end
            end
            ST_SEQ: begin
                w_wr_sel = r_ptr;
                if (w_xfer) begin
                    w_wr_en = 1'b1;
                    if (r_ptr == c_LAST) begin
                        w_done_nxt  = 1'b1;
                        w_ptr_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ptr_nxt = r_ptr + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // Control registers; CLR has the same effect as reset
    always_ff @(posedge CLK) begin
        if (!RST || CLR) begin
            r_state <= ST_INIT;
            r_ready <= 1'b0;
            r_ptr   <= '0;
            r_stb   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != ST_INIT);
            r_ptr   <= w_ptr_nxt;
            r_stb   <= w_wr_onehot;
            r_done  <= w_done_nxt;
        end
    end

    // Destination registers; only the decoded one loads on a transfer
    always_ff @(posedge CLK) begin
        for (int k = 0; k < c_NUM_OUT; k++) begin
            if (!RST || CLR) begin
                r_y[k] <= '0;
            end else if (w_wr_onehot[k]) begin
                r_y[k] <= D;
            end
        end
    end

    assign READY = r_ready;
    assign STB   = r_stb;
    assign PTR   = r_ptr;
    assign DONE  = r_done;
    assign Y0    = r_y[0];
    assign Y1    = r_y[1];
    assign Y2    = r_y[2];
    assign Y3    = r_y[3];
    assign Y4    = r_y[4];
    assign Y5    = r_y[5];
    assign Y6    = r_y[6];
    assign Y7    = r_y[7];
    assign Y8    = r_y[8];
    assign Y9    = r_y[9];
    assign Y10   = r_y[10];
    assign Y11   = r_y[11];
    assign Y12   = r_y[12];
    assign Y13   = r_y[13];
    assign Y14   = r_y[14];
    assign Y15   = r_y[15];

endmodule
`default_nettype wire

// File: tb/tb_demux32_1x16_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux32_1x16_seq
//  Description : Directed self-checking bench for demux32_1x16_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux32_1x16_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] D;
    logic [3:0]  S;
    logic        AUTO;
    logic        VALID;
    logic        READY;
    logic        CLR;
    logic [31:0] Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
    logic [31:0] Y8, Y9, Y10, Y11, Y12, Y13, Y14, Y15;
    logic [15:0] STB;
    logic [3:0]  PTR;
    logic        DONE;

    logic [31:0] w_y   [16];
    logic [31:0] exp_y [16];
    int          n_pass  = 0;
    int          n_total = 0;

    always #5 CLK = ~CLK;

    demux32_1x16_seq u_dut (
        .CLK(CLK), .RST(RST), .D(D), .S(S), .AUTO(AUTO), .VALID(VALID),
        .READY(READY), .CLR(CLR),
        .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4), .Y5(Y5), .Y6(Y6), .Y7(Y7),
        .Y8(Y8), .Y9(Y9), .Y10(Y10), .Y11(Y11), .Y12(Y12), .Y13(Y13),
        .Y14(Y14), .Y15(Y15),
        .STB(STB), .PTR(PTR), .DONE(DONE)
    );

    assign w_y[0]  = Y0;  assign w_y[1]  = Y1;  assign w_y[2]  = Y2;  assign w_y[3]  = Y3;
    assign w_y[4]  = Y4;  assign w_y[5]  = Y5;  assign w_y[6]  = Y6;  assign w_y[7]  = Y7;
    assign w_y[8]  = Y8;  assign w_y[9]  = Y9;  assign w_y[10] = Y10; assign w_y[11] = Y11;
    assign w_y[12] = Y12; assign w_y[13] = Y13; assign w_y[14] = Y14; assign w_y[15] = Y15;

    // Advance one edge and settle before sampling
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0; CLR = 1'b0; VALID = 1'b0; AUTO = 1'b0; S = '0; D = '0;
        tick(); tick();
        for (int k = 0; k < 16; k++) exp_y[k] = '0;
        n_total++; if (READY !== 1'b0) $display("FAIL reset_ready got %b expected 0", READY); else n_pass++;
        n_total++; if (STB !== 16'h0) $display("FAIL reset_stb got %h expected 0000", STB); else n_pass++;
        n_total++; if (PTR !== 4'h0) $display("FAIL reset_ptr got %h expected 0", PTR); else n_pass++;
        n_total++; if (DONE !== 1'b0) $display("FAIL reset_done got %b expected 0", DONE); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_total++;
            if (w_y[k] !== 32'h0) $display("FAIL reset_y%0d got %h expected 0", k, w_y[k]); else n_pass++;
        end
        RST = 1'b1;
        n_total++; if (READY !== 1'b0) $display("FAIL init_ready got %b expected 0", READY); else n_pass++;
        tick();
        n_total++; if (READY !== 1'b1) $display("FAIL idle_ready got %b expected 1", READY); else n_pass++;
    endtask

    task automatic test_addressed();
        VALID = 1'b1; AUTO = 1'b0; S = 4'd5; D = 32'hA5A5_0005;
        tick();
        VALID = 1'b0;
        exp_y[5] = 32'hA5A5_0005;
        n_total++; if (STB !== 16'h0020) $display("FAIL addr_stb got %h expected 0020", STB); else n_pass++;
        n_total++; if (PTR !== 4'h0) $display("FAIL addr_ptr got %h expected 0", PTR); else n_pass++;
        n_total++; if (DONE !== 1'b0) $display("FAIL addr_done got %b expected 0", DONE); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_total++;
            if (w_y[k] !== exp_y[k]) $display("FAIL addr_y%0d got %h expected %h", k, w_y[k], exp_y[k]); else n_pass++;
        end
        tick();
        n_total++; if (STB !== 16'h0) $display("FAIL addr_stb_clear got %h expected 0000", STB); else n_pass++;
        n_total++; if (Y5 !== 32'hA5A5_0005) $display("FAIL addr_hold got %h expected a5a50005", Y5); else n_pass++;
    endtask

    task automatic test_auto();
        logic [15:0] stb_tab  [4] = '{16'h1000, 16'h2000, 16'h4000, 16'h8000};
        logic [3:0]  ptr_tab  [4] = '{4'd13, 4'd14, 4'd15, 4'd0};
        logic        done_tab [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        VALID = 1'b1; AUTO = 1'b1; S = 4'd12;
        for (int i = 0; i < 4; i++) begin
            D = 32'(12 + i);
            tick();
            AUTO = 1'b0; S = 4'd3;
            exp_y[12 + i] = 32'(12 + i);
            n_total++; if (STB !== stb_tab[i]) $display("FAIL auto_stb%0d got %h expected %h", i, STB, stb_tab[i]); else n_pass++;
            n_total++; if (PTR !== ptr_tab[i]) $display("FAIL auto_ptr%0d got %h expected %h", i, PTR, ptr_tab[i]); else n_pass++;
            n_total++; if (DONE !== done_tab[i]) $display("FAIL auto_done%0d got %b expected %b", i, DONE, done_tab[i]); else n_pass++;
        end
        VALID = 1'b0;
        tick();
        n_total++; if (DONE !== 1'b0) $display("FAIL auto_done_clear got %b expected 0", DONE); else n_pass++;
        n_total++; if (STB !== 16'h0) $display("FAIL auto_stb_clear got %h expected 0000", STB); else n_pass++;
        // Back in IDLE: an addressed word must follow S, not the pointer
        VALID = 1'b1; AUTO = 1'b0; S = 4'd3; D = 32'h0000_0333;
        tick();
        VALID = 1'b0;
        exp_y[3] = 32'h0000_0333;
        n_total++; if (STB !== 16'h0008) $display("FAIL auto_idle_stb got %h expected 0008", STB); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_total++;
            if (w_y[k] !== exp_y[k]) $display("FAIL auto_y%0d got %h expected %h", k, w_y[k], exp_y[k]); else n_pass++;
        end
    endtask

    task automatic test_stall();
        VALID = 1'b1; AUTO = 1'b1; S = 4'd0;
        for (int i = 0; i < 16; i++) begin
            D = 32'h100 + 32'(i);
            tick();
            AUTO = 1'b0; S = 4'd9;
            exp_y[i] = 32'h100 + 32'(i);
            n_total++;
            if (STB !== (16'h1 << i)) $display("FAIL stall_stb%0d got %h expected %h", i, STB, 16'h1 << i); else n_pass++;
            n_total++;
            if (DONE !== (i == 15)) $display("FAIL stall_done%0d got %b expected %b", i, DONE, i == 15); else n_pass++;
            if (i == 5) begin
                VALID = 1'b0;
                for (int w = 0; w < 3; w++) begin
                    tick();
                    n_total++; if (STB !== 16'h0) $display("FAIL stall_hold_stb got %h expected 0000", STB); else n_pass++;
                    n_total++; if (PTR !== 4'd6) $display("FAIL stall_hold_ptr got %h expected 6", PTR); else n_pass++;
                    n_total++; if (DONE !== 1'b0) $display("FAIL stall_hold_done got %b expected 0", DONE); else n_pass++;
                end
                n_total++; if (Y6 !== 32'h0) $display("FAIL stall_hold_y6 got %h expected 0", Y6); else n_pass++;
                VALID = 1'b1;
            end
        end
        VALID = 1'b0;
        n_total++; if (PTR !== 4'd0) $display("FAIL stall_end_ptr got %h expected 0", PTR); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_total++;
            if (w_y[k] !== exp_y[k]) $display("FAIL stall_y%0d got %h expected %h", k, w_y[k], exp_y[k]); else n_pass++;
        end
        tick();
    endtask

    task automatic test_auto15();
        VALID = 1'b1; AUTO = 1'b1; S = 4'hF; D = 32'hDEAD_BEEF;
        tick();
        exp_y[15] = 32'hDEAD_BEEF;
        n_total++; if (Y15 !== 32'hDEAD_BEEF) $display("FAIL a15_y15 got %h expected deadbeef", Y15); else n_pass++;
        n_total++; if (DONE !== 1'b1) $display("FAIL a15_done got %b expected 1", DONE); else n_pass++;
        n_total++; if (STB !== 16'h8000) $display("FAIL a15_stb got %h expected 8000", STB); else n_pass++;
        n_total++; if (PTR !== 4'h0) $display("FAIL a15_ptr got %h expected 0", PTR); else n_pass++;
        // Stayed in IDLE: next word goes to S=2
        AUTO = 1'b0; S = 4'd2; D = 32'h2222_0002;
        tick();
        VALID = 1'b0;
        exp_y[2] = 32'h2222_0002;
        n_total++; if (STB !== 16'h0004) $display("FAIL a15_next_stb got %h expected 0004", STB); else n_pass++;
        n_total++; if (DONE !== 1'b0) $display("FAIL a15_next_done got %b expected 0", DONE); else n_pass++;
        n_total++; if (Y2 !== 32'h2222_0002) $display("FAIL a15_next_y2 got %h expected 22220002", Y2); else n_pass++;
        n_total++; if (Y0 !== exp_y[0]) $display("FAIL a15_next_y0 got %h expected %h", Y0, exp_y[0]); else n_pass++;
    endtask

    task automatic test_clr();
        VALID = 1'b1; AUTO = 1'b1; S = 4'd0;
        for (int i = 0; i < 3; i++) begin
            D = 32'(7 + i);
            tick();
            AUTO = 1'b0;
        end
        n_total++; if (PTR !== 4'd3) $display("FAIL clr_pre_ptr got %h expected 3", PTR); else n_pass++;
        CLR = 1'b1; D = 32'hFFFF_FFFF;
        tick();
        CLR = 1'b0; VALID = 1'b0;
        for (int k = 0; k < 16; k++) exp_y[k] = '0;
        n_total++; if (PTR !== 4'h0) $display("FAIL clr_ptr got %h expected 0", PTR); else n_pass++;
        n_total++; if (DONE !== 1'b0) $display("FAIL clr_done got %b expected 0", DONE); else n_pass++;
        n_total++; if (STB !== 16'h0) $display("FAIL clr_stb got %h expected 0000", STB); else n_pass++;
        n_total++; if (READY !== 1'b0) $display("FAIL clr_ready got %b expected 0", READY); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_total++;
            if (w_y[k] !== 32'h0) $display("FAIL clr_y%0d got %h expected 0", k, w_y[k]); else n_pass++;
        end
        tick();
        n_total++; if (READY !== 1'b1) $display("FAIL clr_ready_back got %b expected 1", READY); else n_pass++;
        n_total++; if (DONE !== 1'b0) $display("FAIL clr_no_done got %b expected 0", DONE); else n_pass++;
        // Sequence was aborted: addressed word follows S
        VALID = 1'b1; AUTO = 1'b0; S = 4'd9; D = 32'h9999_0009;
        tick();
        VALID = 1'b0;
        n_total++; if (STB !== 16'h0200) $display("FAIL clr_after_stb got %h expected 0200", STB); else n_pass++;
        n_total++; if (Y9 !== 32'h9999_0009) $display("FAIL clr_after_y9 got %h expected 99990009", Y9); else n_pass++;
        n_total++; if (Y3 !== 32'h0) $display("FAIL clr_after_y3 got %h expected 0", Y3); else n_pass++;
    endtask

    task automatic test_back_to_back();
        VALID = 1'b1; AUTO = 1'b0;
        for (int i = 0; i < 4; i++) begin
            S = 4'(i * 3 + 1);
            D = 32'hB000_0000 + 32'(i);
            tick();
            n_total++;
            if (STB !== (16'h1 << (i * 3 + 1))) $display("FAIL b2b_stb%0d got %h expected %h", i, STB, 16'h1 << (i * 3 + 1)); else n_pass++;
        end
        VALID = 1'b0;
        n_total++; if (Y1 !== 32'hB000_0000) $display("FAIL b2b_y1 got %h expected b0000000", Y1); else n_pass++;
        n_total++; if (Y4 !== 32'hB000_0001) $display("FAIL b2b_y4 got %h expected b0000001", Y4); else n_pass++;
        n_total++; if (Y7 !== 32'hB000_0002) $display("FAIL b2b_y7 got %h expected b0000002", Y7); else n_pass++;
        n_total++; if (Y10 !== 32'hB000_0003) $display("FAIL b2b_y10 got %h expected b0000003", Y10); else n_pass++;
        n_total++; if (Y9 !== 32'h9999_0009) $display("FAIL b2b_y9 got %h expected 99990009", Y9); else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_addressed();
        test_auto();
        test_stall();
        test_auto15();
        test_clr();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux32_1x16_seq.md
Name: demux32_1x16_seq

Overview:
- Registered 1-to-16 demultiplexer for 32-bit words; inverse of the 32-bit 16x1 read mux.
- Routes each accepted input word to one of 16 held output registers Y0..Y15.
- Addressed mode: the destination comes from select S.
- Auto mode: an internal pointer walks the destinations sequentially, as in a register-file load or scatter engine.
- Sits on the write side of register-file and datapath structures; the 16x1 mux reads them back.

Parameters:
- DATA_WIDTH, 32, width of D and each Y output.
- SEL_WIDTH, 4, width of S and PTR; output count is fixed at 2**SEL_WIDTH = 16.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  synchronous reset, active-low.
- D  input  32  data word to distribute.
- S  input  4  destination select (addressed mode); start index (auto mode).
- AUTO  input  1  sampled with an accepted word in IDLE; 1 starts an auto sequence.
- VALID  input  1  D/S/AUTO valid this cycle.
- READY  output  1  block can accept a word; a transfer occurs when VALID & READY at a rising edge.
- CLR  input  1  synchronous clear of all outputs and state, active-high.
- Y0..Y15  output  32 each  held destination registers.
- STB  output  16  one-hot update strobe; bit k high for exactly one cycle after Yk is written.
- PTR  output  4  current auto pointer.
- DONE  output  1  one-cycle pulse when an auto sequence writes Y15.

Behaviour:
- Reset (RST=0 at edge):
  - Y0..Y15=0, STB=0, PTR=0, DONE=0, READY=0.
  - State goes to INIT.
- States are INIT, IDLE and SEQ.
  - INIT: READY=0. Advances to IDLE on the next edge; READY=1 from then.
  - IDLE, transfer with AUTO=0: Y[S]<=D, STB<=onehot(S). Stay in IDLE; PTR unchanged.
  - IDLE, transfer with AUTO=1: Y[S]<=D, STB<=onehot(S).
    - If S!=15: PTR<=S+1, go to SEQ.
    - If S==15: DONE<=1, PTR<=0, stay in IDLE.
  - SEQ: READY=1. Each transfer does Y[PTR]<=D, STB<=onehot(PTR), PTR<=PTR+1. S and AUTO are ignored.
    - When the write hits PTR==15: DONE<=1, PTR<=0, go to IDLE.
    - No wrap-around past 15.
  - No transfer in a cycle: STB<=0, DONE<=0, all Y hold, state holds (SEQ waits indefinitely).
- Latency: a word accepted at edge n is visible on Yk after edge n. STB[k] and DONE are high during cycle n..n+1 only.
- Back-to-back transfers: one word per cycle sustained in both modes; STB moves one-hot each cycle.
- CLR=1 at an edge (RST=1):
  - Same effect as reset: all Y=0, PTR=0, STB=0, DONE=0, state goes to INIT, READY=0 for one cycle.
  - A word presented with CLR is discarded.
  - Upstream must not assert VALID with CLR.
- Priority: RST, then CLR, then transfer.
- Reset or CLR during SEQ aborts the sequence. Previously written Y are cleared; no DONE is issued.
- Non-selected Y registers never change on a transfer.
- READY is registered and depends only on state: 0 in INIT, 1 in IDLE and SEQ.

Decomposition:
- Shared package:
  - DATA_WIDTH=32, SEL_WIDTH=4, NUM_OUT=16.
  - State encoding: INIT=2'b00, IDLE=2'b01, SEQ=2'b10.
- Sub-module decoder_4x16: combinational select-to-one-hot. Drives the per-register write enables and the next STB value; reusable by the register file write port.
- Top level holds the FSM, pointer counter and the 16 output registers.

Test Plan:
- Reset/INIT: RST=0 for 2 cycles then 1 -> all Y=0, PTR=0, READY=0 for one cycle after release, then READY=1.
- Addressed write: VALID=1, AUTO=0, S=4'b0101, D=32'hA5A5_0005 -> Y5=32'hA5A5_0005, STB=16'h0020 for one cycle, other Y unchanged, PTR=0.
- Auto sequence:
  - Stimulus: AUTO=1, S=4'd12, then D=32'd12,13,14,15 on consecutive cycles.
  - Response: Y12..Y15=12..15; STB walks 16'h1000 to 16'h8000; DONE=1 only with STB=16'h8000; state back to IDLE, PTR=0.
- Stalls in SEQ: start auto at S=0, drop VALID for 3 cycles mid-sequence -> PTR and Y hold, STB=0, sequence resumes and DONE after the 16th word.
- Auto at S=15: AUTO=1, S=4'hF, D=32'hDEAD_BEEF -> Y15 written, DONE pulses the same cycle, state stays IDLE.
- CLR mid-sequence: CLR=1 with VALID=1 after 3 auto writes -> all Y=0, PTR=0, no DONE, READY=0 for one cycle, and the presented word is not written.
